// File: rtl/ace_cut_ctrl.sv
// ace_cut_ctrl: outstanding-txn limiter, RACK/WACK generator and flush/quiesce handshake ahead of an ACE cut.
// Latency: zero on all channels (combinational), acks/counters/flush_ack registered one cycle; ACE_CUT_CTRL_ERR_EN enables err_o.
// Backpressure: AW/AR are gated (valid and ready forced low) at full count or while flushing, unless already presented.
package ace_cut_ctrl_pkg;
    typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; } aw_chan_t;
    typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } w_chan_t;
    typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_chan_t;
    typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; } ar_chan_t;
    typedef struct packed { logic [3:0] id; logic [31:0] data; logic [3:0] resp; logic last; } r_chan_t;
    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
        logic     wack;
        logic     rack;
    } axi_req_t;
    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } axi_resp_t;
endpackage

module ace_cut_ctrl #(
    parameter int unsigned MaxTxns    = 8,
    parameter type         aw_chan_t  = ace_cut_ctrl_pkg::aw_chan_t,
    parameter type         w_chan_t   = ace_cut_ctrl_pkg::w_chan_t,
    parameter type         b_chan_t   = ace_cut_ctrl_pkg::b_chan_t,
    parameter type         ar_chan_t  = ace_cut_ctrl_pkg::ar_chan_t,
    parameter type         r_chan_t   = ace_cut_ctrl_pkg::r_chan_t,
    parameter type         axi_req_t  = ace_cut_ctrl_pkg::axi_req_t,
    parameter type         axi_resp_t = ace_cut_ctrl_pkg::axi_resp_t,
    localparam int unsigned CntW      = $clog2(MaxTxns + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  axi_req_t        slv_req_i,
    output axi_resp_t       slv_resp_o,
    output axi_req_t        mst_req_o,
    input  axi_resp_t       mst_resp_i,
    input  logic            flush_req_i,
    output logic            flush_ack_o,
    output logic [CntW-1:0] rd_cnt_o,
    output logic [CntW-1:0] wr_cnt_o,
    output logic            err_o
);
    typedef enum logic [1:0] {Idle, Drain, Quiesced} state_e;

    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTxns);

    state_e          state_q;
    logic [CntW-1:0] rd_cnt_q, wr_cnt_q;
    logic            aw_lock_q, ar_lock_q, rack_q, wack_q, flush_ack_q;
    logic            aw_gate, ar_gate, aw_vld, ar_vld;
    logic            aw_hs, ar_hs, b_hs, r_last_hs, quiet;

    // A channel already presenting a request keeps it, so valid is never withdrawn.
    assign aw_gate   = !aw_lock_q && (state_q != Idle || wr_cnt_q == MaxCnt);
    assign ar_gate   = !ar_lock_q && (state_q != Idle || rd_cnt_q == MaxCnt);
    assign aw_vld    = slv_req_i.aw_valid && !aw_gate;
    assign ar_vld    = slv_req_i.ar_valid && !ar_gate;
    assign aw_hs     = aw_vld && mst_resp_i.aw_ready;
    assign ar_hs     = ar_vld && mst_resp_i.ar_ready;
    assign b_hs      = mst_resp_i.b_valid && slv_req_i.b_ready;
    assign r_last_hs = mst_resp_i.r_valid && slv_req_i.r_ready && mst_resp_i.r.last;
    assign quiet     = rd_cnt_q == '0 && wr_cnt_q == '0 && !aw_lock_q && !ar_lock_q
                       && !rack_q && !wack_q;

    function automatic logic [CntW-1:0] next_cnt(input logic [CntW-1:0] cnt,
                                                 input logic inc, input logic dec);
        if (inc && !dec) return cnt + CntW'(1);
        if (dec && !inc && cnt != '0) return cnt - CntW'(1);
        return cnt;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= Idle;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            aw_lock_q   <= 1'b0;
            ar_lock_q   <= 1'b0;
            rack_q      <= 1'b0;
            wack_q      <= 1'b0;
            flush_ack_q <= 1'b0;
        end else begin
            rd_cnt_q <= next_cnt(rd_cnt_q, ar_hs, r_last_hs);
            wr_cnt_q <= next_cnt(wr_cnt_q, aw_hs, b_hs);
            rack_q   <= r_last_hs;
            wack_q   <= b_hs;
            if (aw_hs)                              aw_lock_q <= 1'b0;
            else if (aw_vld && !mst_resp_i.aw_ready) aw_lock_q <= 1'b1;
            if (ar_hs)                              ar_lock_q <= 1'b0;
            else if (ar_vld && !mst_resp_i.ar_ready) ar_lock_q <= 1'b1;
            // flush_ack_q moves with the state so it is high exactly while Quiesced.
            unique case (state_q)
                Idle: if (flush_req_i) state_q <= Drain;
                Drain: begin
                    if (!flush_req_i) begin
                        state_q <= Idle;
                    end else if (quiet) begin
                        state_q     <= Quiesced;
                        flush_ack_q <= 1'b1;
                    end
                end
                Quiesced: begin
                    if (!flush_req_i) begin
                        state_q     <= Idle;
                        flush_ack_q <= 1'b0;
                    end
                end
                default: state_q <= Idle;
            endcase
        end
    end

`ifdef ACE_CUT_CTRL_ERR_EN
    logic underflow, err_q;
    assign underflow = (r_last_hs && rd_cnt_q == '0) || (b_hs && wr_cnt_q == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_q || underflow;
    end
    assign err_o = err_q;

    underflow_chk: assert property (@(posedge clk_i) disable iff (!rst_ni) !underflow)
        else $error("ace_cut_ctrl: acknowledge without outstanding transaction");
`else
    assign err_o = 1'b0;
`endif

    always_comb begin
        mst_req_o          = slv_req_i;
        mst_req_o.aw       = aw_chan_t'(slv_req_i.aw);
        mst_req_o.w        = w_chan_t'(slv_req_i.w);
        mst_req_o.ar       = ar_chan_t'(slv_req_i.ar);
        mst_req_o.aw_valid = aw_vld;
        mst_req_o.ar_valid = ar_vld;
        mst_req_o.wack     = wack_q;
        mst_req_o.rack     = rack_q;
        slv_resp_o          = mst_resp_i;
        slv_resp_o.b        = b_chan_t'(mst_resp_i.b);
        slv_resp_o.r        = r_chan_t'(mst_resp_i.r);
        slv_resp_o.aw_ready = mst_resp_i.aw_ready && !aw_gate;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready && !ar_gate;
    end

    assign flush_ack_o = flush_ack_q;
    assign rd_cnt_o    = rd_cnt_q;
    assign wr_cnt_o    = wr_cnt_q;
endmodule

// File: tb/tb_ace_cut_ctrl.sv
// Bench for ace_cut_ctrl: directed scenarios plus a randomized run against a transaction-level model.
module tb_ace_cut_ctrl;
    import ace_cut_ctrl_pkg::*;

    localparam int MAX = 3;
    localparam int CW  = $clog2(MAX + 1);
    localparam int RUN = 0, DRN = 1, QUI = 2;

    logic          clk_i  = 1'b0;
    logic          rst_ni = 1'b0;
    axi_req_t      slv_req, mst_req;
    axi_resp_t     slv_resp, mst_resp;
    logic          flush_req, flush_ack, err;
    logic [CW-1:0] rd_cnt, wr_cnt;

    int n_cmp = 0, n_bad = 0;

    // Reference model: outstanding counts, pending acks, flush phase, presented-request flags.
    int m_rd, m_wr, m_phase;
    bit m_rack, m_wack, m_aw_lock, m_ar_lock, m_err;
    bit g_ar_hs, g_aw_hs;

    always #5 clk_i = ~clk_i;

    ace_cut_ctrl #(.MaxTxns(MAX)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .slv_req_i   (slv_req),
        .slv_resp_o  (slv_resp),
        .mst_req_o   (mst_req),
        .mst_resp_i  (mst_resp),
        .flush_req_i (flush_req),
        .flush_ack_o (flush_ack),
        .rd_cnt_o    (rd_cnt),
        .wr_cnt_o    (wr_cnt),
        .err_o       (err)
    );

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit ar_blocked();
        return !m_ar_lock && (m_phase != RUN || m_rd == MAX);
    endfunction

    function automatic bit aw_blocked();
        return !m_aw_lock && (m_phase != RUN || m_wr == MAX);
    endfunction

    task automatic idle_inputs();
        slv_req   = '0;
        mst_resp  = '0;
        flush_req = 1'b0;
    endtask

    task automatic model_reset();
        m_rd = 0; m_wr = 0; m_phase = RUN;
        m_rack = 0; m_wack = 0; m_aw_lock = 0; m_ar_lock = 0; m_err = 0;
        g_ar_hs = 0; g_aw_hs = 0;
    endtask

    // Consume the current cycle's inputs into the model, then move to just after the next edge.
    task automatic adv();
        bit ar_b, aw_b, ar_hs, aw_hs, rl_hs, b_hs, quiet;
        ar_b  = ar_blocked();
        aw_b  = aw_blocked();
        ar_hs = slv_req.ar_valid && !ar_b && mst_resp.ar_ready;
        aw_hs = slv_req.aw_valid && !aw_b && mst_resp.aw_ready;
        rl_hs = mst_resp.r_valid && slv_req.r_ready && mst_resp.r.last;
        b_hs  = mst_resp.b_valid && slv_req.b_ready;
        quiet = m_rd == 0 && m_wr == 0 && !m_ar_lock && !m_aw_lock && !m_rack && !m_wack;
`ifdef ACE_CUT_CTRL_ERR_EN
        if ((rl_hs && m_rd == 0) || (b_hs && m_wr == 0)) m_err = 1;
`endif
        if (ar_hs != rl_hs) m_rd = ar_hs ? m_rd + 1 : (m_rd > 0 ? m_rd - 1 : 0);
        if (aw_hs != b_hs)  m_wr = aw_hs ? m_wr + 1 : (m_wr > 0 ? m_wr - 1 : 0);
        case (m_phase)
            RUN: if (flush_req) m_phase = DRN;
            DRN: if (!flush_req) m_phase = RUN; else if (quiet) m_phase = QUI;
            default: if (!flush_req) m_phase = RUN;
        endcase
        if (ar_hs) m_ar_lock = 0; else if (slv_req.ar_valid && !ar_b) m_ar_lock = 1;
        if (aw_hs) m_aw_lock = 0; else if (slv_req.aw_valid && !aw_b) m_aw_lock = 1;
        m_rack = rl_hs; m_wack = b_hs;
        g_ar_hs = ar_hs; g_aw_hs = aw_hs;
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        n_cmp++; if (rd_cnt !== '0) begin n_bad++; $display("FAIL reset_rd_cnt got=%0d exp=0", rd_cnt); end
        n_cmp++; if (wr_cnt !== '0) begin n_bad++; $display("FAIL reset_wr_cnt got=%0d exp=0", wr_cnt); end
        n_cmp++; if (flush_ack !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL reset_flags got ack=%b err=%b exp 0 0", flush_ack, err); end
        n_cmp++; if (mst_req.rack !== 1'b0 || mst_req.wack !== 1'b0) begin n_bad++; $display("FAIL reset_acks got rack=%b wack=%b exp 0 0", mst_req.rack, mst_req.wack); end
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;
        model_reset();
    endtask

    task automatic test_ar_limit();
        slv_req.ar_valid = 1; mst_resp.ar_ready = 1; slv_req.r_ready = 1;
        for (int i = 0; i <= MAX; i++) begin
            slv_req.ar.addr = 32'h100 + 32'(i);
            @(negedge clk_i);
            n_cmp++; if (slv_resp.ar_ready !== (i < MAX)) begin n_bad++; $display("FAIL lim_ar_ready i=%0d got=%b exp=%b", i, slv_resp.ar_ready, i < MAX); end
            n_cmp++; if (rd_cnt !== CW'(i)) begin n_bad++; $display("FAIL lim_rd_cnt i=%0d got=%0d exp=%0d", i, rd_cnt, i); end
            adv();
        end
        mst_resp.r_valid = 1; mst_resp.r.last = 1; mst_resp.r.data = 32'hcafe_0001;
        @(negedge clk_i);
        n_cmp++; if (slv_resp.ar_ready !== 1'b0) begin n_bad++; $display("FAIL lim_no_bypass got=%b exp=0", slv_resp.ar_ready); end
        n_cmp++; if (slv_resp.r.data !== 32'hcafe_0001) begin n_bad++; $display("FAIL lim_r_data got=%h exp=cafe0001", slv_resp.r.data); end
        adv();
        mst_resp.r_valid = 0;
        @(negedge clk_i);
        n_cmp++; if (slv_resp.ar_ready !== 1'b1 || rd_cnt !== CW'(MAX - 1)) begin n_bad++; $display("FAIL lim_ungate got ready=%b cnt=%0d exp 1 %0d", slv_resp.ar_ready, rd_cnt, MAX - 1); end
        n_cmp++; if (mst_req.ar.addr !== 32'h100 + 32'(MAX)) begin n_bad++; $display("FAIL lim_held_addr got=%h exp=%h", mst_req.ar.addr, 32'h100 + MAX); end
        adv();
        slv_req.ar_valid = 0; mst_resp.r_valid = 1;
        repeat (MAX) adv();
        mst_resp.r_valid = 0;
        @(negedge clk_i);
        n_cmp++; if (rd_cnt !== '0 || mst_req.rack !== 1'b1) begin n_bad++; $display("FAIL lim_drain got cnt=%0d rack=%b exp 0 1", rd_cnt, mst_req.rack); end
        adv();
    endtask

    task automatic test_acks();
        slv_req.aw_valid = 1; mst_resp.aw_ready = 1; slv_req.b_ready = 1;
        adv();
        slv_req.aw_valid = 0;
        repeat (3) adv();
        mst_resp.b_valid = 1;
        @(negedge clk_i);
        n_cmp++; if (mst_req.wack !== 1'b0) begin n_bad++; $display("FAIL ack_wack_early got=%b exp=0", mst_req.wack); end
        adv();
        mst_resp.b_valid = 0;
        @(negedge clk_i);
        n_cmp++; if (mst_req.wack !== 1'b1 || wr_cnt !== '0) begin n_bad++; $display("FAIL ack_wack_pulse got wack=%b cnt=%0d exp 1 0", mst_req.wack, wr_cnt); end
        adv();
        @(negedge clk_i);
        n_cmp++; if (mst_req.wack !== 1'b0) begin n_bad++; $display("FAIL ack_wack_len got=%b exp=0", mst_req.wack); end
        slv_req.ar_valid = 1;
        adv();
        slv_req.ar_valid = 0; mst_resp.r_valid = 1; mst_resp.r.last = 0;
        adv();
        mst_resp.r.last = 1;
        @(negedge clk_i);
        n_cmp++; if (mst_req.rack !== 1'b0 || rd_cnt !== CW'(1)) begin n_bad++; $display("FAIL ack_rack_nonlast got rack=%b cnt=%0d exp 0 1", mst_req.rack, rd_cnt); end
        adv();
        mst_resp.r_valid = 0;
        @(negedge clk_i);
        n_cmp++; if (mst_req.rack !== 1'b1 || rd_cnt !== '0) begin n_bad++; $display("FAIL ack_rack_last got rack=%b cnt=%0d exp 1 0", mst_req.rack, rd_cnt); end
        adv();
        @(negedge clk_i);
        n_cmp++; if (mst_req.rack !== 1'b0) begin n_bad++; $display("FAIL ack_rack_len got=%b exp=0", mst_req.rack); end
        adv();
    endtask

    task automatic test_flush_stalled_ar();
        slv_req.ar_valid = 1; slv_req.ar.addr = 32'h0000_5a5a; mst_resp.ar_ready = 0;
        adv();
        flush_req = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            n_cmp++; if (mst_req.ar_valid !== 1'b1) begin n_bad++; $display("FAIL fls_ar_held i=%0d got=%b exp=1", i, mst_req.ar_valid); end
            adv();
        end
        mst_resp.ar_ready = 1;
        adv();
        slv_req.ar_valid = 0; mst_resp.ar_ready = 0;
        mst_resp.r_valid = 1; mst_resp.r.last = 1;
        @(negedge clk_i);
        n_cmp++; if (rd_cnt !== CW'(1) || flush_ack !== 1'b0) begin n_bad++; $display("FAIL fls_accepted got cnt=%0d ack=%b exp 1 0", rd_cnt, flush_ack); end
        adv();
        mst_resp.r_valid = 0;
        @(negedge clk_i);
        n_cmp++; if (mst_req.rack !== 1'b1 || flush_ack !== 1'b0) begin n_bad++; $display("FAIL fls_rack got rack=%b ack=%b exp 1 0", mst_req.rack, flush_ack); end
        adv();
        @(negedge clk_i);
        n_cmp++; if (flush_ack !== 1'b0) begin n_bad++; $display("FAIL fls_ack_early got=%b exp=0", flush_ack); end
        adv();
        @(negedge clk_i);
        n_cmp++; if (flush_ack !== 1'b1) begin n_bad++; $display("FAIL fls_ack_rise got=%b exp=1", flush_ack); end
        flush_req = 0;
        adv();
        adv();
    endtask

    task automatic test_flush_idle();
        flush_req = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk_i);
            n_cmp++; if (flush_ack !== 1'b0) begin n_bad++; $display("FAIL idle_ack_c%0d got=%b exp=0", c, flush_ack); end
            adv();
        end
        flush_req = 0; slv_req.ar_valid = 1; mst_resp.ar_ready = 1;
        @(negedge clk_i);
        n_cmp++; if (flush_ack !== 1'b1 || slv_resp.ar_ready !== 1'b0) begin n_bad++; $display("FAIL idle_quiesced got ack=%b ready=%b exp 1 0", flush_ack, slv_resp.ar_ready); end
        adv();
        @(negedge clk_i);
        n_cmp++; if (flush_ack !== 1'b0 || slv_resp.ar_ready !== 1'b1) begin n_bad++; $display("FAIL idle_resume got ack=%b ready=%b exp 0 1", flush_ack, slv_resp.ar_ready); end
        adv();
        slv_req.ar_valid = 0; mst_resp.r_valid = 1; mst_resp.r.last = 1;
        adv();
        mst_resp.r_valid = 0;
        adv();
    endtask

    task automatic test_simul_aw_b();
        slv_req.aw_valid = 1; mst_resp.aw_ready = 1;
        adv();
        mst_resp.b_valid = 1;
        @(negedge clk_i);
        n_cmp++; if (wr_cnt !== CW'(1)) begin n_bad++; $display("FAIL sim_pre got=%0d exp=1", wr_cnt); end
        adv();
        slv_req.aw_valid = 0;
        @(negedge clk_i);
        n_cmp++; if (wr_cnt !== CW'(1) || mst_req.wack !== 1'b1) begin n_bad++; $display("FAIL sim_hold got cnt=%0d wack=%b exp 1 1", wr_cnt, mst_req.wack); end
        adv();
        mst_resp.b_valid = 0;
        @(negedge clk_i);
        n_cmp++; if (wr_cnt !== '0) begin n_bad++; $display("FAIL sim_drain got=%0d exp=0", wr_cnt); end
        adv();
    endtask

    task automatic test_underflow();
        bit exp_err;
`ifdef ACE_CUT_CTRL_ERR_EN
        exp_err = 1;
`else
        exp_err = 0;
`endif
        mst_resp.b_valid = 1; slv_req.b_ready = 1;
        adv();
        mst_resp.b_valid = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            n_cmp++; if (wr_cnt !== '0 || err !== exp_err || mst_req.wack !== (c == 0)) begin n_bad++; $display("FAIL uf_c%0d got cnt=%0d err=%b wack=%b exp 0 %b %b", c, wr_cnt, err, mst_req.wack, exp_err, c == 0); end
            adv();
        end
    endtask

    task automatic test_reset_mid();
        slv_req.ar_valid = 1; mst_resp.ar_ready = 1;
        repeat (MAX) adv();
        slv_req.ar_valid = 0; flush_req = 1;
        adv();
        @(negedge clk_i);
        n_cmp++; if (rd_cnt !== CW'(MAX) || flush_ack !== 1'b0) begin n_bad++; $display("FAIL rm_pre got cnt=%0d ack=%b exp %0d 0", rd_cnt, flush_ack, MAX); end
        #2 rst_ni = 1'b0;
        #1;
        n_cmp++; if (rd_cnt !== '0 || wr_cnt !== '0 || flush_ack !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rm_async got rd=%0d wr=%0d ack=%b err=%b exp all 0", rd_cnt, wr_cnt, flush_ack, err); end
        idle_inputs();
        @(negedge clk_i) rst_ni = 1'b1;
        @(posedge clk_i); #1;
        model_reset();
        slv_req.ar_valid = 1; mst_resp.ar_ready = 1; slv_req.r_ready = 1;
        @(negedge clk_i);
        n_cmp++; if (slv_resp.ar_ready !== 1'b1 || mst_req.rack !== 1'b0) begin n_bad++; $display("FAIL rm_idle got ready=%b rack=%b exp 1 0", slv_resp.ar_ready, mst_req.rack); end
        adv();
        slv_req.ar_valid = 0; mst_resp.r_valid = 1; mst_resp.r.last = 1;
        adv();
        idle_inputs();
        adv();
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            if (!(slv_req.ar_valid && !g_ar_hs)) begin slv_req.ar_valid = rb(); slv_req.ar.addr = $urandom; end
            if (!(slv_req.aw_valid && !g_aw_hs)) begin slv_req.aw_valid = rb(); slv_req.aw.addr = $urandom; end
            mst_resp.ar_ready = rb();
            mst_resp.aw_ready = rb();
            slv_req.w_valid = rb(); slv_req.w.data = $urandom;
            mst_resp.r_valid = (m_rd > 0) && rb(); mst_resp.r.last = rb(); mst_resp.r.data = $urandom;
            mst_resp.b_valid = (m_wr > 0) && rb();
            slv_req.r_ready = rb(); slv_req.b_ready = rb();
            if ($urandom_range(0, 15) == 0) flush_req = !flush_req;
            @(negedge clk_i);
            n_cmp++; if (slv_resp.ar_ready !== (mst_resp.ar_ready && !ar_blocked()) || mst_req.ar_valid !== (slv_req.ar_valid && !ar_blocked())) begin n_bad++; $display("FAIL rnd_ar c=%0d got v=%b r=%b blocked_model=%b", c, mst_req.ar_valid, slv_resp.ar_ready, ar_blocked()); end
            n_cmp++; if (slv_resp.aw_ready !== (mst_resp.aw_ready && !aw_blocked()) || mst_req.aw_valid !== (slv_req.aw_valid && !aw_blocked())) begin n_bad++; $display("FAIL rnd_aw c=%0d got v=%b r=%b blocked_model=%b", c, mst_req.aw_valid, slv_resp.aw_ready, aw_blocked()); end
            n_cmp++; if (rd_cnt !== CW'(m_rd) || wr_cnt !== CW'(m_wr)) begin n_bad++; $display("FAIL rnd_cnt c=%0d got rd=%0d wr=%0d exp %0d %0d", c, rd_cnt, wr_cnt, m_rd, m_wr); end
            n_cmp++; if (mst_req.rack !== m_rack || mst_req.wack !== m_wack) begin n_bad++; $display("FAIL rnd_ack c=%0d got rack=%b wack=%b exp %b %b", c, mst_req.rack, mst_req.wack, m_rack, m_wack); end
            n_cmp++; if (flush_ack !== (m_phase == QUI) || err !== m_err) begin n_bad++; $display("FAIL rnd_flush c=%0d got ack=%b err=%b exp %b %b", c, flush_ack, err, m_phase == QUI, m_err); end
            n_cmp++; if (mst_req.w.data !== slv_req.w.data || mst_req.w_valid !== slv_req.w_valid || slv_resp.r.data !== mst_resp.r.data) begin n_bad++; $display("FAIL rnd_pass c=%0d got w=%h r=%h exp %h %h", c, mst_req.w.data, slv_resp.r.data, slv_req.w.data, mst_resp.r.data); end
            adv();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ar_limit();
        test_acks();
        test_flush_stalled_ar();
        test_flush_idle();
        test_simul_aw_b();
        test_underflow();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
